// File: rtl/serv_ctrl_wide.sv
// PC/control unit that updates the 32-bit program counter W bits per beat.
// Produces the next fetch address, the rd writeback stream and a misaligned-target flag.
`timescale 1ns/1ps
module serv_ctrl_wide #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          W          = 1,
    parameter bit          COMPRESSED = 1'b1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_pc_en,
    input  logic         i_jump,
    input  logic         i_jal_or_jalr,
    input  logic         i_utype,
    input  logic         i_pc_rel,
    input  logic         i_trap,
    input  logic         i_iscomp,
    input  logic [W-1:0] i_imm,
    input  logic [W-1:0] i_buf,
    input  logic [W-1:0] i_csr_pc,
    output logic [W-1:0] o_rd,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_bad_pc,
    output logic [31:0]  o_ibus_adr
);
    // state | meaning
    // IDLE  | o_ibus_adr holds the fetch address, waiting for i_start
    // RUN   | one W-bit beat per cycle, PC rotating through the datapath
    localparam int N  = 32 / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W1 = W + 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic          cy4_q, cy4_d;
    logic          cyo_q, cyo_d;
    logic          bad_q, bad_d;

    logic [W-1:0]  pc, inc_s, off_a, off_b, csr_clr, aligned, pc_inc, pc_off, new_pc;
    logic [W-1:0]  bit0_m, bit1_m, imm_keep;
    logic [W:0]    sum_inc, sum_off;
    logic          inc_two, last;

    // Per-bit masks derived from the absolute bit index of this beat.
    always_comb begin
        bit0_m   = '0;
        bit1_m   = '0;
        imm_keep = '0;
        inc_s    = '0;
        inc_two  = i_iscomp && COMPRESSED;
        for (int j = 0; j < W; j++) begin
            bit0_m[j]   = (int'(cnt_q) * W + j == 0);
            bit1_m[j]   = (int'(cnt_q) * W + j == 1);
            imm_keep[j] = (int'(cnt_q) * W + j >= 12);
            if (int'(cnt_q) * W + j == 1)
                inc_s[j] = inc_two;
            else if (int'(cnt_q) * W + j == 2)
                inc_s[j] = !inc_two;
        end
    end

    always_comb begin
        pc      = adr_q[W-1:0];
        off_a   = i_pc_rel ? pc : '0;
        off_b   = i_utype ? (i_imm & imm_keep) : i_buf;
        sum_inc = {1'b0, pc} + {1'b0, inc_s} + W1'(cy4_q);
        sum_off = {1'b0, off_a} + {1'b0, off_b} + W1'(cyo_q);
        pc_inc  = sum_inc[W-1:0];
        pc_off  = sum_off[W-1:0];
        aligned = pc_off & ~bit0_m;
        csr_clr = i_csr_pc & ~bit0_m;
        if (!i_pc_en)
            new_pc = pc;
        else if (i_trap)
            new_pc = csr_clr;
        else if (i_jump)
            new_pc = aligned;
        else
            new_pc = pc_inc;
    end

    assign last = (state_q == RUN) && (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        cy4_d   = cy4_q;
        cyo_d   = cyo_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    cy4_d   = 1'b0;
                    cyo_d   = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            RUN: begin
                adr_d = {new_pc, adr_q[31:W]};
                cy4_d = last ? 1'b0 : sum_inc[W];
                cyo_d = last ? 1'b0 : sum_off[W];
                if (!COMPRESSED && i_jump && !i_trap && |(aligned & bit1_m))
                    bad_d = 1'b1;
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= RESET_PC;
            cy4_q   <= 1'b0;
            cyo_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            cy4_q   <= cy4_d;
            cyo_q   <= cyo_d;
            bad_q   <= bad_d;
        end
    end

    assign o_rd       = (state_q == RUN) ? ((aligned & {W{i_utype}}) | (pc_inc & {W{i_jal_or_jalr}})) : '0;
    assign o_busy     = (state_q == RUN);
    assign o_done     = last;
    assign o_bad_pc   = bad_q;
    assign o_ibus_adr = adr_q;
endmodule

// File: tb/tb_serv_ctrl_wide.sv
// Scoreboard bench for serv_ctrl_wide: two W=4 instances (RVC on/off) share stimulus,
// expected results come from a whole-word reference model.
`timescale 1ns/1ps
module tb_serv_ctrl_wide;
    localparam int          W   = 4;
    localparam int          N   = 32 / W;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, pc_en, jump, jal, utype, pc_rel, trap, iscomp;
    logic [W-1:0] imm_s, buf_s, csr_s;
    logic [W-1:0] rd_a, rd_b;
    logic         busy_a, busy_b, done_a, done_b, bad_a, bad_b;
    logic [31:0]  adr_a, adr_b;

    serv_ctrl_wide #(.RESET_PC(RPC), .W(W), .COMPRESSED(1'b1)) u_dut_c (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pc_en(pc_en), .i_jump(jump),
        .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap),
        .i_iscomp(iscomp), .i_imm(imm_s), .i_buf(buf_s), .i_csr_pc(csr_s),
        .o_rd(rd_a), .o_busy(busy_a), .o_done(done_a), .o_bad_pc(bad_a), .o_ibus_adr(adr_a));

    serv_ctrl_wide #(.RESET_PC(RPC), .W(W), .COMPRESSED(1'b0)) u_dut_nc (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pc_en(pc_en), .i_jump(jump),
        .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap),
        .i_iscomp(iscomp), .i_imm(imm_s), .i_buf(buf_s), .i_csr_pc(csr_s),
        .o_rd(rd_b), .o_busy(busy_b), .o_done(done_b), .o_bad_pc(bad_b), .o_ibus_adr(adr_b));

    typedef struct packed {
        logic        pc_en, jump, jal, utype, pc_rel, trap, iscomp;
        logic [31:0] imm, bufv, csr;
    } op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd;
        logic        bad;
    } res_t;

    typedef struct packed {
        res_t a;
        res_t b;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc_a, pc_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: plain 32-bit arithmetic on the full operands.
    function automatic res_t model(input bit comp, input logic [31:0] pc, input op_t op);
        res_t        r;
        logic [31:0] inc, pinc, offb, al;
        inc  = (op.iscomp && comp) ? 32'd2 : 32'd4;
        pinc = pc + inc;
        offb = op.utype ? (op.imm & 32'hFFFF_F000) : op.bufv;
        al   = ((op.pc_rel ? pc : 32'd0) + offb) & 32'hFFFF_FFFE;
        r.rd = (op.utype ? al : 32'd0) | (op.jal ? pinc : 32'd0);
        if (!op.pc_en)     r.pc = pc;
        else if (op.trap)  r.pc = op.csr & 32'hFFFF_FFFE;
        else if (op.jump)  r.pc = al;
        else               r.pc = pinc;
        r.bad = !comp && op.jump && !op.trap && al[1];
        return r;
    endfunction

    function automatic op_t mk(input logic pe, input logic jp, input logic jl, input logic ut,
                               input logic pr, input logic tr, input logic ic,
                               input logic [31:0] im, input logic [31:0] bf, input logic [31:0] cs);
        op_t o;
        o.pc_en = pe; o.jump = jp; o.jal = jl; o.utype = ut; o.pc_rel = pr;
        o.trap = tr; o.iscomp = ic; o.imm = im; o.bufv = bf; o.csr = cs;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom),
                  $urandom, $urandom, $urandom);
    endfunction

    // abort_at >= 0 pulls reset during that beat; the pushed expectation is then flushed.
    task automatic run_op(input op_t op, input int abort_at);
        exp_t        e;
        logic [31:0] im, bf, cs;
        im = op.imm; bf = op.bufv; cs = op.csr;
        @(posedge clk); #1;
        start  = 1'b1;
        pc_en  = op.pc_en;  jump   = op.jump;   jal  = op.jal;   utype  = op.utype;
        pc_rel = op.pc_rel; trap   = op.trap;   iscomp = op.iscomp;
        e.a = model(1'b1, pc_a, op);
        e.b = model(1'b0, pc_b, op);
        sb.push_back(e);
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            start = 1'($urandom);
            imm_s = im[k*W +: W];
            buf_s = bf[k*W +: W];
            csr_s = cs[k*W +: W];
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                start = 1'b0;
                pc_a  = RPC;
                pc_b  = RPC;
                return;
            end
        end
        pc_a = e.a.pc;
        pc_b = e.b.pc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // Monitor: collects o_rd slices during RUN and checks the finished operation once idle.
    initial begin : monitor
        int          beat;
        bit          rst_seen;
        logic [31:0] acc_a, acc_b;
        exp_t        e;
        beat = 0; rst_seen = 1'b0; acc_a = '0; acc_b = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                rst_seen = 1'b1;
                sb.delete();
                beat = 0;
                continue;
            end
            if (rst_seen) begin
                rst_seen = 1'b0;
                chk("reset_adr_c", adr_a, RPC);
                chk("reset_adr_nc", adr_b, RPC);
                chk("reset_busy", {30'd0, busy_a, busy_b}, 32'd0);
                chk("reset_bad", {30'd0, bad_a, bad_b}, 32'd0);
            end
            if (busy_a === 1'b1) begin
                chk("run_len", 32'(beat < N), 32'd1);
                chk("busy_nc", {31'd0, busy_b}, 32'd1);
                chk("done_c", {31'd0, done_a}, 32'(beat == N - 1));
                chk("done_nc", {31'd0, done_b}, 32'(beat == N - 1));
                acc_a = {rd_a, acc_a[31:W]};
                acc_b = {rd_b, acc_b[31:W]};
                beat++;
            end else begin
                chk("idle_flags", {29'd0, busy_b, done_a, done_b}, 32'd0);
                chk("idle_rd", {24'd0, rd_a, rd_b}, 32'd0);
                if (beat != 0) begin
                    chk("beats", beat, N);
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("adr_c", adr_a, e.a.pc);
                        chk("adr_nc", adr_b, e.b.pc);
                        chk("rd_c", acc_a, e.a.rd);
                        chk("rd_nc", acc_b, e.b.rd);
                        chk("bad_c", {31'd0, bad_a}, {31'd0, e.a.bad});
                        chk("bad_nc", {31'd0, bad_b}, {31'd0, e.b.bad});
                    end
                    beat = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        rst_n = 1'b0; start = 1'b1;
        pc_en = 1'b0; jump = 1'b0; jal = 1'b0; utype = 1'b0; pc_rel = 1'b0;
        trap = 1'b0; iscomp = 1'b0; imm_s = '0; buf_s = '0; csr_s = '0;
        pc_a = RPC; pc_b = RPC;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);

        run_op(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0), -1);
        run_op(mk(1, 0, 1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0), -1);
        run_op(mk(1, 1, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFF0, 32'h0), -1);
        run_op(mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0006, 32'h0), -1);
        run_op(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0), -1);
        run_op(mk(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h8000_0001), -1);
        run_op(mk(0, 1, 1, 0, 1, 0, 0, 32'h0, 32'h1234_5678, 32'h0), -1);
        run_op(mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0), -1);
        run_op(mk(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0), -1);
        run_op(mk(1, 0, 0, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0), -1);
        run_op(mk(1, 0, 0, 1, 0, 0, 0, 32'h8765_4FFF, 32'h0, 32'h0), -1);
        run_op(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0), 3);
        run_op(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0), -1);

        for (int i = 0; i < 60; i++)
            run_op(rand_op(), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : -1);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
